// File: rtl/trace_pkg.sv
// Shared types for the retire trace checker: golden record layout, FSM states, end marker.
// Record layout (MSB..LSB): pc[101:70], instr[69:38], wen[37], waddr[36:32], wdata[31:0].
// The packed struct and the bit offsets describe the same layout; keep them in step.
package trace_pkg;

  localparam int REC_W     = 102;
  localparam int WDATA_LSB = 0;
  localparam int WADDR_LSB = 32;
  localparam int WEN_BIT   = 37;
  localparam int INSTR_LSB = 38;
  localparam int PC_LSB    = 70;

  localparam logic [31:0] END_INSTR_DEFAULT = 32'h0000000d;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_RUN,
    ST_DONE,
    ST_FAIL
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } rec_t;

  // A retire matches its golden record when pc, instr and wen agree; the
  // destination and data only matter for a real write (r0 is hardwired zero).
  function automatic logic rec_match(input rec_t exp_rec, input rec_t act_rec);
    logic m;
    m = (exp_rec.pc == act_rec.pc) && (exp_rec.instr == act_rec.instr) &&
        (exp_rec.wen == act_rec.wen);
    if (exp_rec.wen && (exp_rec.waddr != 5'd0)) begin
      m = m && (exp_rec.waddr == act_rec.waddr) && (exp_rec.wdata == act_rec.wdata);
    end
    return m;
  endfunction

endpackage

// File: rtl/retire_fifo.sv
// Synchronous DEPTH x W FIFO buffering retire events ahead of the comparator.
// Latency: a pushed entry is visible on dout_o the cycle after the push.
// Backpressure: push is ignored while full (even with a same-cycle pop); flush empties it.
module retire_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = REC_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q];

  // Pointer and occupancy tracking; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
    end
  end

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push && !rst && !flush_i) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/retire_trace_checker.sv
// Golden-trace checker: compares buffered MW-stage retires against records fetched from memory.
// Latency: compare/pop 1 cycle after FIFO non-empty in RUN; >=3 cycles + memory latency per record.
// Backpressure: retire_ready = !fifo_full; optional macro TRACE_CHECK_CONTINUE_EN keeps going after mismatches.
module retire_trace_checker
  import trace_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter int          AW        = 12,
  parameter logic [31:0] END_INSTR = END_INSTR_DEFAULT,
  parameter int          TIMEOUT   = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             retire_valid,
  input  logic [31:0]      retire_pc,
  input  logic [31:0]      retire_instr,
  input  logic             retire_wen,
  input  logic [4:0]       retire_waddr,
  input  logic [31:0]      retire_wdata,
  output logic             retire_ready,
  output logic             gold_req,
  output logic [AW-1:0]    gold_addr,
  input  logic             gold_valid,
  input  logic [REC_W-1:0] gold_rec,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [15:0]      mismatch_count,
  output logic [31:0]      checked_count,
  output logic [31:0]      fail_pc
);

  state_e           state_q;
  rec_t             gold_q;
  logic [AW-1:0]    gold_addr_q;
  logic             gold_req_q, busy_q, done_q, pass_q, timeout_q;
  logic [15:0]      mism_q;
  logic [31:0]      checked_q, fail_pc_q, wd_q;

  logic [REC_W-1:0] retire_rec, fifo_dout;
  logic             fifo_full, fifo_empty, restart, push, pop, is_match;
  rec_t             gold_in;

  // Pack the retire event into the same layout as a golden record.
  always_comb begin
    retire_rec = '0;
    retire_rec[PC_LSB +: 32]    = retire_pc;
    retire_rec[INSTR_LSB +: 32] = retire_instr;
    retire_rec[WEN_BIT]         = retire_wen;
    retire_rec[WADDR_LSB +: 5]  = retire_waddr;
    retire_rec[WDATA_LSB +: 32] = retire_wdata;
  end

  // A start while a check is in flight flushes the FIFO and drops any same-cycle push.
  assign restart  = start && busy_q;
  assign push     = retire_valid && !fifo_full && !restart;
  assign pop      = (state_q == ST_RUN) && !fifo_empty && !start;
  assign is_match = rec_match(gold_q, rec_t'(fifo_dout));
  assign gold_in  = rec_t'(gold_rec);

  retire_fifo #(.DEPTH(DEPTH), .W(REC_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (restart),
    .push_i  (push),
    .din_i   (retire_rec),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Check sequencer: fetch a record, wait for it, compare one retire, repeat until end or failure.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gold_q      <= '0;
      gold_addr_q <= '0;
      gold_req_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      mism_q      <= '0;
      checked_q   <= '0;
      fail_pc_q   <= '0;
      wd_q        <= '0;
    end else if (start) begin
      state_q     <= ST_FETCH;
      gold_addr_q <= '0;
      gold_req_q  <= 1'b1;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      mism_q      <= '0;
      checked_q   <= '0;
      fail_pc_q   <= '0;
      wd_q        <= '0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          gold_req_q <= 1'b0;
          state_q    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (gold_valid) begin
            gold_q <= gold_in;
            if (gold_in.instr == END_INSTR) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (mism_q == 16'd0) && !timeout_q;
            end else begin
              state_q <= ST_RUN;
              wd_q    <= '0;
            end
          end
        end
        ST_RUN: begin
          if (!fifo_empty) begin
            wd_q        <= '0;
            checked_q   <= checked_q + 32'd1;
            gold_addr_q <= gold_addr_q + 1'b1;
            if (is_match) begin
              state_q    <= ST_FETCH;
              gold_req_q <= 1'b1;
            end else begin
              if (mism_q != 16'hFFFF) mism_q <= mism_q + 16'd1;
              if (mism_q == 16'd0) fail_pc_q <= gold_q.pc;
`ifdef TRACE_CHECK_CONTINUE_EN
              state_q    <= ST_FETCH;
              gold_req_q <= 1'b1;
`else
              state_q    <= ST_FAIL;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              pass_q     <= 1'b0;
`endif
            end
          end else if (wd_q == 32'(TIMEOUT - 1)) begin
            timeout_q <= 1'b1;
            fail_pc_q <= gold_q.pc;
            state_q   <= ST_FAIL;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            pass_q    <= 1'b0;
          end else begin
            wd_q <= wd_q + 32'd1;
          end
        end
        ST_IDLE, ST_DONE, ST_FAIL: begin
          gold_req_q <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign retire_ready   = !fifo_full;
  assign gold_req       = gold_req_q;
  assign gold_addr      = gold_addr_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign timeout        = timeout_q;
  assign mismatch_count = mism_q;
  assign checked_count  = checked_q;
  assign fail_pc        = fail_pc_q;

endmodule

// File: tb/tb_retire_trace_checker.sv
module tb_retire_trace_checker;

  localparam logic [31:0] END_I = 32'h0000000d;
`ifdef TRACE_CHECK_CONTINUE_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1, start = 1'b0;
  logic         retire_valid = 1'b0, retire_wen = 1'b0;
  logic [31:0]  retire_pc = '0, retire_instr = '0, retire_wdata = '0;
  logic [4:0]   retire_waddr = '0;
  logic         retire_ready, gold_req, gold_valid = 1'b0;
  logic [11:0]  gold_addr;
  logic [101:0] gold_rec = '0;
  logic         busy, done, pass, timeout;
  logic [15:0]  mismatch_count;
  logic [31:0]  checked_count, fail_pc;

  always #5 clk = ~clk;

  retire_trace_checker #(.DEPTH(4), .AW(12), .END_INSTR(END_I), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_instr(retire_instr),
    .retire_wen(retire_wen), .retire_waddr(retire_waddr), .retire_wdata(retire_wdata),
    .retire_ready(retire_ready), .gold_req(gold_req), .gold_addr(gold_addr),
    .gold_valid(gold_valid), .gold_rec(gold_rec), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .mismatch_count(mismatch_count), .checked_count(checked_count),
    .fail_pc(fail_pc)
  );

  int tests = 0;
  int fails = 0;

  logic [101:0] gold_mem [16];
  logic [101:0] ret_q [$];
  int gold_lat = 1;
  int first_low;

  // Expected results from the reference model
  bit e_pass, e_to;
  int e_checked, e_mism;
  logic [31:0] e_failpc;

  function automatic logic [101:0] mk(input logic [31:0] pc, input logic [31:0] ins,
                                      input logic wen, input logic [4:0] wa, input logic [31:0] wd);
    return {pc, ins, wen, wa, wd};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Golden memory: answers each request after gold_lat cycles with a one-cycle valid pulse.
  initial begin
    int pend = 0;
    logic [11:0] paddr = '0;
    forever begin
      @(negedge clk);
      gold_valid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          gold_valid = 1'b1;
          gold_rec   = gold_mem[paddr[3:0]];
        end
      end
      if (gold_req) begin
        paddr = gold_addr;
        pend  = gold_lat;
      end
    end
  end

  // Reference model: walk the golden list against the retire list.
  task automatic model();
    logic [101:0] g, r;
    bit term, ok;
    e_checked = 0; e_mism = 0; e_failpc = '0; e_to = 0; term = 0;
    for (int i = 0; i < 16 && !term; i++) begin
      g = gold_mem[i];
      if (g[69:38] == END_I) begin
        term = 1;
      end else if (i >= ret_q.size()) begin
        e_to = 1; e_failpc = g[101:70]; term = 1;
      end else begin
        r  = ret_q[i];
        ok = (g[101:70] == r[101:70]) && (g[69:38] == r[69:38]) && (g[37] == r[37]);
        if (g[37] && g[36:32] != 5'd0)
          ok = ok && (g[36:32] == r[36:32]) && (g[31:0] == r[31:0]);
        e_checked++;
        if (!ok) begin
          e_mism++;
          if (e_mism == 1) e_failpc = g[101:70];
          if (!CONT) term = 1;
        end
      end
    end
    e_pass = (e_mism == 0) && !e_to;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic drive_one(input logic [101:0] r, inout int accepted, output bit giveup);
    int n = 0;
    giveup = 0;
    retire_valid = 1'b1;
    {retire_pc, retire_instr, retire_wen, retire_waddr, retire_wdata} = r;
    while (!retire_ready && n < 40) begin
      if (first_low < 0) first_low = accepted;
      @(negedge clk);
      n++;
    end
    if (!retire_ready) begin
      giveup = 1;
    end else begin
      @(negedge clk);
      accepted++;
    end
    retire_valid = 1'b0;
  endtask

  task automatic run_check(input string tag, input int lat, input int gap);
    int n, accepted;
    bit giveup;
    model();
    gold_lat = lat; first_low = -1; accepted = 0; giveup = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < ret_q.size() && !giveup; i++) begin
      repeat (gap) @(negedge clk);
      drive_one(ret_q[i], accepted, giveup);
    end
    n = 0;
    while (!done && n < 500) begin
      @(negedge clk);
      n++;
    end
    check({tag, "/done"}, done, 1);
    check({tag, "/pass"}, pass, e_pass);
    check({tag, "/timeout"}, timeout, e_to);
    check({tag, "/checked"}, checked_count, e_checked);
    check({tag, "/mismatch"}, mismatch_count, e_mism);
    check({tag, "/fail_pc"}, fail_pc, e_failpc);
  endtask

  task automatic load_basic();
    for (int i = 0; i < 16; i++) gold_mem[i] = mk(32'hFFFF_0000, END_I, 1'b0, 5'd0, 32'd0);
    gold_mem[0] = mk(32'h0000_3000, 32'h2010_0001, 1'b1, 5'd8, 32'h0000_0001);
    gold_mem[1] = mk(32'h0000_3004, 32'h2011_0005, 1'b1, 5'd9, 32'h0000_0005);
    gold_mem[2] = mk(32'h0000_3008, 32'hAC08_0000, 1'b0, 5'd0, 32'h0000_0000);
    gold_mem[3] = mk(32'h0000_300C, END_I, 1'b0, 5'd0, 32'd0);
    ret_q.delete();
    for (int i = 0; i < 3; i++) ret_q.push_back(gold_mem[i]);
  endtask

  initial begin
    int n, nrec;
    logic [101:0] r;
    bit gu;
    int acc;

    // Global guard: never hang.
    fork
      begin
        #1000000;
        $display("FAIL global_timeout observed=hang expected=finish");
        $fatal(1, "simulation did not finish");
      end
    join_none

    for (int i = 0; i < 16; i++) gold_mem[i] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst/retire_ready", retire_ready, 1);
    check("rst/busy", busy, 0);
    check("rst/done", done, 0);
    check("rst/pass", pass, 0);
    check("rst/timeout", timeout, 0);
    check("rst/mismatch", mismatch_count, 0);
    check("rst/checked", checked_count, 0);
    check("rst/fail_pc", fail_pc, 0);
    check("rst/gold_req", gold_req, 0);
    check("rst/gold_addr", gold_addr, 0);

    // Three matching retires spaced 5 cycles apart
    load_basic();
    run_check("basic", 2, 5);
    check("basic/pass_lit", pass, 1);
    check("basic/checked_lit", checked_count, 3);

    // Wrong write data on record 2
    do_reset();
    load_basic();
    r = ret_q[1]; r[31:0] = 32'h0000_0006; ret_q[1] = r;
    run_check("wdata_mis", 2, 3);
    check("wdata_mis/fail_pc_lit", fail_pc, 32'h0000_3004);
    check("wdata_mis/mism_lit", mismatch_count, 1);

    // Write to r0: data is ignored
    do_reset();
    load_basic();
    gold_mem[1] = mk(32'h0000_3004, 32'h2000_0005, 1'b1, 5'd0, 32'h0000_0000);
    ret_q[1] = mk(32'h0000_3004, 32'h2000_0005, 1'b1, 5'd0, 32'hDEAD_BEEF);
    run_check("r0_write", 1, 2);
    check("r0_write/pass_lit", pass, 1);

    // Burst of 6 back-to-back retires, memory latency 4
    do_reset();
    for (int i = 0; i < 16; i++) gold_mem[i] = mk(32'hFFFF_0000, END_I, 1'b0, 5'd0, 32'd0);
    ret_q.delete();
    for (int i = 0; i < 6; i++) begin
      gold_mem[i] = mk(32'h0000_4000 + 32'(4 * i), 32'h2000_0100 + 32'(i), 1'b1, 5'(i + 1), 32'(100 + i));
      ret_q.push_back(gold_mem[i]);
    end
    run_check("burst", 4, 0);
    check("burst/pushes_before_full", first_low, 4);
    check("burst/checked_lit", checked_count, 6);

    // No retires at all -> watchdog
    do_reset();
    load_basic();
    ret_q.delete();
    run_check("timeout", 1, 0);
    check("timeout/fail_pc_lit", fail_pc, 32'h0000_3000);

    // Reset while waiting on the second golden read
    do_reset();
    load_basic();
    gold_lat = 6;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    acc = 0;
    drive_one(ret_q[0], acc, gu);
    n = 0;
    while (checked_count != 32'd1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("rstwait/pre_busy", busy, 1);
    check("rstwait/pre_addr", gold_addr, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstwait/busy", busy, 0);
    check("rstwait/checked", checked_count, 0);
    check("rstwait/mismatch", mismatch_count, 0);
    check("rstwait/gold_addr", gold_addr, 0);
    check("rstwait/ready", retire_ready, 1);
    check("rstwait/done", done, 0);
    repeat (12) @(negedge clk);
    load_basic();
    run_check("after_rst", 3, 1);

    // Randomized runs against the model
    for (int it = 0; it < 8; it++) begin
      do_reset();
      nrec = $urandom_range(1, 5);
      for (int i = 0; i < 16; i++) gold_mem[i] = mk(32'hFFFF_0000, END_I, 1'b0, 5'd0, 32'd0);
      ret_q.delete();
      for (int i = 0; i < nrec; i++) begin
        gold_mem[i] = mk($urandom, $urandom | 32'h100, 1'($urandom), 5'($urandom), $urandom);
        ret_q.push_back(gold_mem[i]);
      end
      if ($urandom_range(0, 2) == 0) begin
        int k = $urandom_range(0, nrec - 1);
        r = ret_q[k];
        case ($urandom_range(0, 4))
          0: r[101:70] = r[101:70] ^ 32'h4;
          1: r[69:38]  = r[69:38] ^ 32'h8000;
          2: r[37]     = ~r[37];
          3: r[36:32]  = r[36:32] ^ 5'h1;
          default: r[31:0] = r[31:0] + 32'd1;
        endcase
        ret_q[k] = r;
      end
      if ($urandom_range(0, 5) == 0) void'(ret_q.pop_back());
      run_check($sformatf("rand%0d", it), $urandom_range(1, 4), $urandom_range(0, 4));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
